cfu_dot_engine: RTL and testbench



---
 rtl/cfu_dot_pkg.sv | 33 +++
 rtl/cfu_dot_simd_mac.sv | 41 ++++
 rtl/cfu_dot_engine.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cfu_dot_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_dot_pkg.sv
// Shared types and constants for the cfu_dot_engine dot-product CFU.
// Holds the function-id and FSM state enums, the fixed Wishbone sideband
// values, and the MAC datapath widths.
package cfu_dot_pkg;

  localparam int unsigned OFFSET_W = 9;   // signed input offset width
  localparam int unsigned PROD_W   = 19;  // per-lane signed product width
  localparam int unsigned MAC_W    = 21;  // 4-lane signed sum width

  localparam logic [3:0] CFU_SEL = 4'hF;
  localparam logic [2:0] CFU_CTI = 3'b000;
  localparam logic [1:0] CFU_BTE = 2'b00;

  typedef enum logic [2:0] {
    FN_SET_OFFSET = 3'd0,
    FN_SET_LEN    = 3'd1,
    FN_CLEAR      = 3'd2,
    FN_RUN        = 3'd3,
    FN_READ_ACC   = 3'd4,
    FN_STATUS     = 3'd5,
    FN_NOP6       = 3'd6,
    FN_NOP7       = 3'd7
  } fn_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_A = 3'd1,
    ST_FETCH_B = 3'd2,
    ST_MAC     = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

endpackage

// File: rtl/cfu_dot_simd_mac.sv
// Combinational 4-lane offset-multiply-sum.
// Ports: a_word_i (4 signed activation bytes), b_word_i (4 filter bytes,
// signed or unsigned per FILTER_SIGNED), offset_i (9-bit signed offset added
// to each activation), sum_o (21-bit signed sum of the four products).
module cfu_dot_simd_mac
  import cfu_dot_pkg::*;
#(
  parameter int FILTER_SIGNED = 1
) (
  input  logic [31:0]               a_word_i,
  input  logic [31:0]               b_word_i,
  input  logic [OFFSET_W-1:0]       offset_i,
  output logic signed [MAC_W-1:0]   sum_o
);

  logic [7:0]               a_byte;
  logic [7:0]               b_byte;
  logic [9:0]               a_off;
  logic [8:0]               f_val;
  logic signed [PROD_W-1:0] prod;

  // Range of a_off is -384..382, so 10 bits never overflow.
  always_comb begin
    sum_o  = '0;
    a_byte = '0;
    b_byte = '0;
    a_off  = '0;
    f_val  = '0;
    prod   = '0;
    for (int k = 0; k < 4; k++) begin
      a_byte = a_word_i[8*k +: 8];
      b_byte = b_word_i[8*k +: 8];
      a_off  = {{2{a_byte[7]}}, a_byte} + {offset_i[OFFSET_W-1], offset_i};
      f_val  = (FILTER_SIGNED != 0) ? {b_byte[7], b_byte} : {1'b0, b_byte};
      prod   = $signed({{(PROD_W-10){a_off[9]}}, a_off})
             * $signed({{(PROD_W-9){f_val[8]}}, f_val});
      sum_o  = sum_o + MAC_W'(prod);
    end
  end

endmodule

// File: rtl/cfu_dot_engine.sv
// Variable-length int8 dot-product CFU with its own Wishbone read master.
// Ports: clk/reset (async active-high); cmd_* CFU command channel;
// rsp_* CFU response channel; cfu_ram_* classic Wishbone master (reads only).
// Optional feature macro: CFU_DOT_RETRY_EN enables per-access retry on
// cfu_ram_err (up to RETRY_MAX consecutive errors before aborting).
module cfu_dot_engine
  import cfu_dot_pkg::*;
#(
  parameter int LEN_W         = 10,
  parameter int ACC_W         = 32,
  parameter int FILTER_SIGNED = 1,
  parameter int RETRY_MAX     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic [29:0] cfu_ram_adr,
  output logic [31:0] cfu_ram_dat_mosi,
  output logic [3:0]  cfu_ram_sel,
  output logic        cfu_ram_cyc,
  output logic        cfu_ram_stb,
  output logic        cfu_ram_we,
  output logic [2:0]  cfu_ram_cti,
  output logic [1:0]  cfu_ram_bte,
  input  logic [31:0] cfu_ram_dat_miso,
  input  logic        cfu_ram_ack,
  input  logic        cfu_ram_err
);

  state_e                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_q, rsp_d;
  logic                   cyc_q, cyc_d;
  logic [29:0]            adr_q, adr_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [OFFSET_W-1:0]    offset_q, offset_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [29:0]            a_base_q, a_base_d;
  logic [29:0]            b_base_q, b_base_d;
  logic [31:0]            a_word_q, a_word_d;
  logic [31:0]            b_word_q, b_word_d;
  logic                   busy_err_q, busy_err_d;
  logic                   retry_seen;
  logic                   abort;
  logic                   bus_ack, bus_err;
  fn_e                    fn;
  logic signed [MAC_W-1:0] mac_sum;
  logic [ACC_W-1:0]       acc_sum;
  logic [31:0]            acc_ext, acc_sum_ext;
  logic                   unused_ok;

`ifdef CFU_DOT_RETRY_EN
  localparam int unsigned RC_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
  logic            retry_seen_q, retry_seen_d;
  logic [RC_W-1:0] retry_cnt_q, retry_cnt_d;
  assign retry_seen = retry_seen_q;
  assign unused_ok  = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[1:0]};
`else
  assign retry_seen = 1'b0;
  assign unused_ok  = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[1:0],
                        (RETRY_MAX > 0)};
`endif

  cfu_dot_simd_mac #(.FILTER_SIGNED(FILTER_SIGNED)) u_mac (
    .a_word_i (a_word_q),
    .b_word_i (b_word_q),
    .offset_i (offset_q),
    .sum_o    (mac_sum)
  );

  assign fn          = fn_e'(cmd_payload_function_id[2:0]);
  assign bus_err     = cyc_q & cfu_ram_err;
  assign bus_ack     = cyc_q & cfu_ram_ack & ~cfu_ram_err;  // err wins over ack
  assign acc_sum     = acc_q + ACC_W'(mac_sum);
  assign acc_ext     = 32'($signed(acc_q));
  assign acc_sum_ext = 32'($signed(acc_sum));

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    acc_d       = acc_q;
    offset_d    = offset_q;
    len_d       = len_q;
    idx_d       = idx_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    a_word_d    = a_word_q;
    b_word_d    = b_word_q;
    busy_err_d  = busy_err_q;
    abort       = 1'b0;
`ifdef CFU_DOT_RETRY_EN
    retry_seen_d = retry_seen_q;
    retry_cnt_d  = retry_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_d       = 32'd0;
          case (fn)
            FN_SET_OFFSET: offset_d = cmd_payload_inputs_0[OFFSET_W-1:0];
            FN_SET_LEN:    len_d    = cmd_payload_inputs_0[LEN_W-1:0];
            FN_CLEAR: begin
              rsp_d = acc_ext;
              acc_d = '0;
            end
            FN_RUN: begin
              a_base_d = cmd_payload_inputs_0[31:2];
              b_base_d = cmd_payload_inputs_1[31:2];
              idx_d    = '0;
              rsp_d    = acc_ext;
              if (len_q != '0) begin
                state_d     = ST_FETCH_A;
                rsp_valid_d = 1'b0;
                cyc_d       = 1'b1;
                adr_d       = cmd_payload_inputs_0[31:2];
              end
            end
            FN_READ_ACC: rsp_d = acc_ext;
            FN_STATUS: begin
              rsp_d      = {30'd0, busy_err_q, retry_seen};
              busy_err_d = 1'b0;
`ifdef CFU_DOT_RETRY_EN
              retry_seen_d = 1'b0;
`endif
            end
            default: rsp_d = 32'hFFFF_FFFF;
          endcase
        end
      end

      ST_FETCH_A, ST_FETCH_B: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;  // retry gap over; reissue the held address
        end else if (bus_err) begin
`ifdef CFU_DOT_RETRY_EN
          if (int'(retry_cnt_q) + 1 >= RETRY_MAX) begin
            abort = 1'b1;
          end else begin
            retry_cnt_d  = retry_cnt_q + RC_W'(1);
            retry_seen_d = 1'b1;
            cyc_d        = 1'b0;
          end
`else
          abort = 1'b1;
`endif
        end else if (bus_ack) begin
`ifdef CFU_DOT_RETRY_EN
          retry_cnt_d = '0;
`endif
          if (state_q == ST_FETCH_A) begin
            a_word_d = cfu_ram_dat_miso;
            state_d  = ST_FETCH_B;
            adr_d    = b_base_q + 30'(idx_q);
          end else begin
            b_word_d = cfu_ram_dat_miso;
            state_d  = ST_MAC;
            cyc_d    = 1'b0;
          end
        end
      end

      ST_MAC: begin
        acc_d = acc_sum;
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_d       = acc_sum_ext;
        end else begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = ST_FETCH_A;
          cyc_d   = 1'b1;
          adr_d   = a_base_q + 30'(idx_q + LEN_W'(1));
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abandon the run; pairs already accumulated stay in acc.
    if (abort) begin
      cyc_d       = 1'b0;
      busy_err_d  = 1'b1;
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_d       = acc_ext;
`ifdef CFU_DOT_RETRY_EN
      retry_cnt_d = '0;
`endif
    end

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      acc_q       <= '0;
      offset_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      a_word_q    <= '0;
      b_word_q    <= '0;
      busy_err_q  <= 1'b0;
`ifdef CFU_DOT_RETRY_EN
      retry_seen_q <= 1'b0;
      retry_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      acc_q       <= acc_d;
      offset_q    <= offset_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      a_word_q    <= a_word_d;
      b_word_q    <= b_word_d;
      busy_err_q  <= busy_err_d;
`ifdef CFU_DOT_RETRY_EN
      retry_seen_q <= retry_seen_d;
      retry_cnt_q  <= retry_cnt_d;
`endif
    end
  end

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_q;
  assign cfu_ram_adr           = adr_q;
  assign cfu_ram_cyc           = cyc_q;
  assign cfu_ram_stb           = cyc_q;
  assign cfu_ram_dat_mosi      = 32'd0;
  assign cfu_ram_sel           = CFU_SEL;
  assign cfu_ram_we            = 1'b0;
  assign cfu_ram_cti           = CFU_CTI;
  assign cfu_ram_bte           = CFU_BTE;

endmodule

// File: tb/tb_cfu_dot_engine.sv
// Directed self-checking bench for cfu_dot_engine with a small Wishbone
// memory model, error injection and ack stalling.
module tb_cfu_dot_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  fid = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_payload;
  logic [29:0] ram_adr;
  logic [31:0] ram_mosi;
  logic [3:0]  ram_sel;
  logic        ram_cyc, ram_stb, ram_we;
  logic [2:0]  ram_cti;
  logic [1:0]  ram_bte;
  logic [31:0] ram_miso;
  logic        ram_ack, ram_err;

  logic [31:0] mem [0:63];
  int          rd_cnt = 0;
  logic [29:0] rd_adr [0:15];
  int          cyc_cnt = 0;
  int          err_seen = 0;
  int          err_budget = 0;
  logic [29:0] err_adr = '0;
  logic        stall_en = 1'b0;
  logic [29:0] stall_adr = '0;
  logic        err_now;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cfu_dot_engine dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload),
    .cfu_ram_adr             (ram_adr),
    .cfu_ram_dat_mosi        (ram_mosi),
    .cfu_ram_sel             (ram_sel),
    .cfu_ram_cyc             (ram_cyc),
    .cfu_ram_stb             (ram_stb),
    .cfu_ram_we              (ram_we),
    .cfu_ram_cti             (ram_cti),
    .cfu_ram_bte             (ram_bte),
    .cfu_ram_dat_miso        (ram_miso),
    .cfu_ram_ack             (ram_ack),
    .cfu_ram_err             (ram_err)
  );

  // Zero-wait-state slave with optional error injection and ack stall.
  assign err_now  = ram_stb && (ram_adr == err_adr) && (err_seen < err_budget);
  assign ram_err  = err_now;
  assign ram_ack  = ram_stb && !err_now && !(stall_en && ram_adr == stall_adr);
  assign ram_miso = mem[ram_adr[5:0]];

  always @(posedge clk) begin
    if (ram_stb && ram_ack && !ram_err) begin
      rd_adr[rd_cnt % 16] <= ram_adr;
      rd_cnt <= rd_cnt + 1;
    end
    if (ram_cyc) cyc_cnt <= cyc_cnt + 1;
    if (err_now) err_seen <= err_seen + 1;
  end

  task automatic send_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rsp, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; fid = f; in0 = a; in1 = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout fn=%0d waited %0d cycles, required rsp_valid=1", f, lat);
    end
    rsp = rsp_payload;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, ram_cyc, ram_stb} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got rdy/vld/cyc/stb=%b required 1000",
               {cmd_ready, rsp_valid, ram_cyc, ram_stb});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_payload !== 32'd0 || ram_adr !== 30'd0 || ram_sel !== 4'hF || ram_we !== 1'b0 ||
        ram_mosi !== 32'd0 || ram_cti !== 3'd0 || ram_bte !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got payload=%h adr=%h sel=%h required 0/0/F", rsp_payload,
               ram_adr, ram_sel);
    end
  endtask

  task automatic test_single_pair();
    logic [31:0] r; int lat; int rd0;
    mem[4] = 32'h0000_0000; mem[8] = 32'h0101_0101;
    send_cmd(10'd0, 32'd128, 32'd0, r, lat);
    checks++;
    if (r !== 32'd0 || lat != 0) begin
      errors++; $display("FAIL set_offset got %h lat %0d required 0 lat 0", r, lat);
    end
    send_cmd(10'd1, 32'd1, 32'd0, r, lat);
    rd0 = rd_cnt;
    send_cmd(10'd3, 32'd16, 32'd32, r, lat);
    checks++;
    if (r !== 32'd512) begin errors++; $display("FAIL single_rsp got %0d required 512", r); end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL single_lat got %0d required 3", lat); end
    checks++;
    if (rd_cnt - rd0 != 2 || rd_adr[rd0 % 16] !== 30'd4 || rd_adr[(rd0 + 1) % 16] !== 30'd8) begin
      errors++;
      $display("FAIL single_reads got n=%0d adr %0d,%0d required 2 reads adr 4,8",
               rd_cnt - rd0, rd_adr[rd0 % 16], rd_adr[(rd0 + 1) % 16]);
    end
  endtask

  task automatic test_multi_pair();
    logic [31:0] r; int lat;
    send_cmd(10'd2, 32'd0, 32'd0, r, lat);
    checks++;
    if (r !== 32'd512) begin errors++; $display("FAIL clear_prev got %0d required 512", r); end
    for (int i = 0; i < 3; i++) begin mem[16+i] = 32'hFFFF_FFFF; mem[24+i] = 32'h0202_0202; end
    send_cmd(10'd0, 32'd0, 32'd0, r, lat);
    send_cmd(10'd1, 32'd3, 32'd0, r, lat);
    send_cmd(10'd3, 32'd64, 32'd96, r, lat);
    checks++;
    if (r !== 32'hFFFF_FFE8 || lat != 9) begin
      errors++; $display("FAIL multi_rsp got %h lat %0d required ffffffe8 lat 9", r, lat);
    end
    send_cmd(10'd2, 32'd0, 32'd0, r, lat);
    checks++;
    if (r !== 32'hFFFF_FFE8) begin errors++; $display("FAIL clear_neg got %h required ffffffe8", r); end
    send_cmd(10'd4, 32'd0, 32'd0, r, lat);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL read_after_clear got %h required 0", r); end
  endtask

  task automatic test_len_zero();
    logic [31:0] r; int lat; int c0;
    mem[20] = 32'h0102_0304; mem[28] = 32'h0101_0101;
    send_cmd(10'd1, 32'd1, 32'd0, r, lat);
    send_cmd(10'd3, 32'd80, 32'd112, r, lat);
    checks++;
    if (r !== 32'd10) begin errors++; $display("FAIL lanes_rsp got %0d required 10", r); end
    send_cmd(10'd1, 32'd0, 32'd0, r, lat);
    c0 = cyc_cnt;
    send_cmd(10'd3, 32'd80, 32'd112, r, lat);
    checks++;
    if (r !== 32'd10 || lat != 0 || cyc_cnt != c0) begin
      errors++;
      $display("FAIL len0_run got %0d lat %0d cyc %0d required 10 lat 0 cyc 0", r, lat, cyc_cnt - c0);
    end
  endtask

  task automatic test_extremes_and_nop();
    logic [31:0] r; int lat;
    send_cmd(10'd2, 32'd0, 32'd0, r, lat);
    checks++;
    if (r !== 32'd10) begin errors++; $display("FAIL clear_10 got %0d required 10", r); end
    mem[48] = 32'h8080_8080; mem[56] = 32'h8080_8080;
    send_cmd(10'd0, 32'h0000_0100, 32'd0, r, lat);  // offset -256
    send_cmd(10'd1, 32'd1, 32'd0, r, lat);
    send_cmd(10'd3, 32'd192, 32'd224, r, lat);
    checks++;
    if (r !== 32'd196608) begin errors++; $display("FAIL extreme_rsp got %0d required 196608", r); end
    send_cmd(10'h3FE, 32'd5, 32'd5, r, lat);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nop6 got %h required ffffffff", r); end
    send_cmd(10'd7, 32'd0, 32'd0, r, lat);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nop7 got %h required ffffffff", r); end
  endtask

  task automatic test_bus_err();
    logic [31:0] r; int lat;
    logic [31:0] exp_rsp, exp_stat; int exp_lat;
`ifdef CFU_DOT_RETRY_EN
    exp_rsp = 32'd24; exp_stat = 32'd1; exp_lat = 8;
`else
    exp_rsp = 32'd12; exp_stat = 32'd2; exp_lat = 5;
`endif
    send_cmd(10'd2, 32'd0, 32'd0, r, lat);
    send_cmd(10'd0, 32'd0, 32'd0, r, lat);
    send_cmd(10'd1, 32'd2, 32'd0, r, lat);
    mem[32] = 32'h0101_0101; mem[33] = 32'h0101_0101;
    mem[40] = 32'h0303_0303; mem[41] = 32'h0303_0303;
    err_adr = 30'd41; err_budget = err_seen + 1;
    send_cmd(10'd3, 32'd128, 32'd160, r, lat);
    checks++;
    if (r !== exp_rsp || lat != exp_lat) begin
      errors++;
      $display("FAIL err_rsp got %0d lat %0d required %0d lat %0d", r, lat, exp_rsp, exp_lat);
    end
    send_cmd(10'd5, 32'd0, 32'd0, r, lat);
    checks++;
    if (r !== exp_stat) begin errors++; $display("FAIL status1 got %0d required %0d", r, exp_stat); end
    send_cmd(10'd5, 32'd0, 32'd0, r, lat);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL status2 got %0d required 0", r); end
  endtask

  task automatic test_rsp_hold();
    logic [31:0] exp_acc;
`ifdef CFU_DOT_RETRY_EN
    exp_acc = 32'd24;
`else
    exp_acc = 32'd12;
`endif
    @(negedge clk);
    cmd_valid = 1'b1; fid = 10'd4; in0 = '0; in1 = '0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_payload !== exp_acc || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc %0d got vld=%b data=%0d rdy=%b required 1/%0d/0", i, rsp_valid,
                 rsp_payload, cmd_ready, exp_acc);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release got vld=%b rdy=%b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat;
    send_cmd(10'd1, 32'd1, 32'd0, r, lat);
    stall_en = 1'b1; stall_adr = 30'd8;
    @(negedge clk);
    cmd_valid = 1'b1; fid = 10'd3; in0 = 32'd16; in1 = 32'd32;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ram_cyc !== 1'b1 || ram_adr !== 30'd8) begin
      errors++; $display("FAIL stall_fetch_b got cyc=%b adr=%0d required 1/8", ram_cyc, ram_adr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ram_cyc !== 1'b0 || ram_stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got cyc=%b stb=%b vld=%b rdy=%b required 0/0/0/1", ram_cyc,
               ram_stb, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0; stall_en = 1'b0;
    send_cmd(10'd4, 32'd0, 32'd0, r, lat);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL acc_after_reset got %0d required 0", r); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    for (int i = 0; i < 16; i++) rd_adr[i] = 30'd0;
    test_reset();
    test_single_pair();
    test_multi_pair();
    test_len_zero();
    test_extremes_and_nop();
    test_bus_err();
    test_rsp_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
